// File: rtl/as2650_xbus_ctrl_if.sv
// Request/response and multiplexed-bus signals of the AS2650 external-bus sequencer.
// The optional ready_i input exists only when AS2650_XBUS_READY_EN is defined.
interface as2650_xbus_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [DATA_W-1:0] bus_o;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_i;
    logic              le_hi;
    logic              le_lo;
    logic              OEb;
    logic              WEb;
`ifdef AS2650_XBUS_READY_EN
    logic              ready_i;
`endif

    // Sequencer view: takes requests and pad inputs, drives strobes and bus.
    modport slave (
`ifdef AS2650_XBUS_READY_EN
        input  ready_i,
`endif
        input  req_valid, req_we, req_addr, req_wdata, bus_i,
        output req_ready, rsp_valid, rsp_rdata, bus_o, bus_oe, le_hi, le_lo, OEb, WEb
    );

    // Core/pad view: issues requests and returns pad data.
    modport master (
`ifdef AS2650_XBUS_READY_EN
        output ready_i,
`endif
        output req_valid, req_we, req_addr, req_wdata, bus_i,
        input  req_ready, rsp_valid, rsp_rdata, bus_o, bus_oe, le_hi, le_lo, OEb, WEb
    );
endinterface

// File: rtl/as2650_xbus_ctrl.sv
// AS2650 external-bus sequencer: turns single read/write requests into multiplexed
// address/data cycles (le_hi, le_lo, OEb, WEb) on a shared bus.
// Optional feature macro: AS2650_XBUS_READY_EN adds an external ready input that
// stretches the DATA phase once the programmed wait cycles have elapsed.
module as2650_xbus_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          HI_REUSE    = 1'b1
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    as2650_xbus_ctrl_if.slave xb
);
    localparam int unsigned HI_W = ADDR_W - DATA_W;

    typedef enum logic [2:0] {
        StIdle, StAhi, StAhiH, StAlo, StAloH, StData, StWrH
    } state_t;

    state_t            state;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [HI_W-1:0]   last_hi;
    logic              hi_valid;
    logic [3:0]        wait_cnt;
    logic              hi_hit;
    logic              data_done;

    // High address byte already held in the external latch: skip the AHI phase.
    always_comb begin
        hi_hit = HI_REUSE && hi_valid && (xb.req_addr[ADDR_W-1:DATA_W] == last_hi);
    end

    // Last DATA cycle: wait states consumed (and external ready, when present).
    always_comb begin
`ifdef AS2650_XBUS_READY_EN
        data_done = (wait_cnt == 4'd0) && xb.ready_i;
`else
        data_done = (wait_cnt == 4'd0);
`endif
    end

    // Sequencer FSM; every bus-facing output is registered here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= StIdle;
            cur_we       <= 1'b0;
            cur_addr     <= '0;
            cur_wdata    <= '0;
            last_hi      <= '0;
            hi_valid     <= 1'b0;
            wait_cnt     <= 4'd0;
            xb.req_ready <= 1'b1;
            xb.rsp_valid <= 1'b0;
            xb.rsp_rdata <= '0;
            xb.bus_o     <= '0;
            xb.bus_oe    <= 1'b0;
            xb.le_hi     <= 1'b0;
            xb.le_lo     <= 1'b0;
            xb.OEb       <= 1'b1;
            xb.WEb       <= 1'b1;
        end else begin
            xb.rsp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (xb.req_valid) begin
                        cur_we       <= xb.req_we;
                        cur_addr     <= xb.req_addr;
                        cur_wdata    <= xb.req_wdata;
                        xb.req_ready <= 1'b0;
                        xb.bus_oe    <= 1'b1;
                        if (hi_hit) begin
                            xb.bus_o <= xb.req_addr[DATA_W-1:0];
                            xb.le_lo <= 1'b1;
                            state    <= StAlo;
                        end else begin
                            xb.bus_o <= DATA_W'(xb.req_addr[ADDR_W-1:DATA_W]);
                            xb.le_hi <= 1'b1;
                            state    <= StAhi;
                        end
                    end
                end
                StAhi: begin
                    xb.le_hi <= 1'b0;
                    state    <= StAhiH;
                end
                StAhiH: begin
                    // Latch now holds this high part; remember it for reuse.
                    last_hi  <= cur_addr[ADDR_W-1:DATA_W];
                    hi_valid <= 1'b1;
                    xb.bus_o <= cur_addr[DATA_W-1:0];
                    xb.le_lo <= 1'b1;
                    state    <= StAlo;
                end
                StAlo: begin
                    xb.le_lo <= 1'b0;
                    state    <= StAloH;
                end
                StAloH: begin
                    wait_cnt <= 4'(WAIT_CYCLES);
                    if (cur_we) begin
                        xb.bus_o <= cur_wdata;
                        xb.WEb   <= 1'b0;
                    end else begin
                        xb.bus_oe <= 1'b0;
                        xb.OEb    <= 1'b0;
                    end
                    state <= StData;
                end
                StData: begin
                    if (data_done) begin
                        if (cur_we) begin
                            xb.WEb <= 1'b1;
                            state  <= StWrH;
                        end else begin
                            xb.OEb       <= 1'b1;
                            xb.rsp_rdata <= xb.bus_i;
                            xb.rsp_valid <= 1'b1;
                            xb.req_ready <= 1'b1;
                            state        <= StIdle;
                        end
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StWrH: begin
                    xb.bus_oe    <= 1'b0;
                    xb.rsp_valid <= 1'b1;
                    xb.req_ready <= 1'b1;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_as2650_xbus_ctrl.sv
// Directed bench for as2650_xbus_ctrl: one instance with no wait states, one with two.
// A negedge monitor counts strobe activity per transaction and models the external
// memory for the closing random stream.
module tb_as2650_xbus_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    as2650_xbus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) xa ();
    as2650_xbus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) xb ();

    as2650_xbus_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0), .HI_REUSE(1'b1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .xb(xa)
    );
    as2650_xbus_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2), .HI_REUSE(1'b1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .xb(xb)
    );

    logic [7:0] bus_a, bus_b, mem_bus;
    bit         mem_mode = 1'b0;
    assign xa.bus_i = mem_mode ? mem_bus : bus_a;
    assign xb.bus_i = bus_b;
`ifdef AS2650_XBUS_READY_EN
    logic rdy_a = 1'b1;
    assign xa.ready_i = rdy_a;
    assign xb.ready_i = 1'b1;
`endif

    // Monitor state, cleared whenever clr_gen moves.
    int         mon_sel = 0;
    int         clr_gen = 0, seen_gen = 0;
    int         cyc, n_lehi, n_lelo, n_oe, n_we, n_rsp, n_conf, oe_first;
    logic [7:0] hi_lat, lo_lat, wbus, wrh_bus;
    logic       wrh_oe;
    logic       prev_web = 1'b1;
    logic [7:0] ext_hi = 8'h00, ext_lo = 8'h00;
    logic [7:0] ext_mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ext_rd(input logic [15:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Per-cycle strobe monitor and pad-side memory for instance a.
    always @(negedge clk) begin
        logic       lh, ll, oeb, web, boe, rv;
        logic [7:0] bo;
        if (seen_gen != clr_gen) begin
            seen_gen = clr_gen;
            cyc = 0; n_lehi = 0; n_lelo = 0; n_oe = 0; n_we = 0; n_rsp = 0; n_conf = 0;
            oe_first = 0; hi_lat = 0; lo_lat = 0; wbus = 0; wrh_bus = 0; wrh_oe = 0;
        end
        if (mon_sel == 0) begin
            lh = xa.le_hi; ll = xa.le_lo; oeb = xa.OEb; web = xa.WEb;
            boe = xa.bus_oe; rv = xa.rsp_valid; bo = xa.bus_o;
        end else begin
            lh = xb.le_hi; ll = xb.le_lo; oeb = xb.OEb; web = xb.WEb;
            boe = xb.bus_oe; rv = xb.rsp_valid; bo = xb.bus_o;
        end
        cyc++;
        if (lh) begin n_lehi++; hi_lat = bo; end
        if (ll) begin n_lelo++; lo_lat = bo; end
        if (!oeb) begin
            n_oe++;
            if (oe_first == 0) oe_first = cyc;
            if (boe) n_conf++;
        end
        if (!web) begin
            n_we++;
            wbus = bo;
            if (!boe) n_conf++;
        end
        if (!oeb && !web) n_conf++;
        if (!prev_web && web) begin wrh_bus = bo; wrh_oe = boe; end
        prev_web = web;
        if (rv) n_rsp++;
        if (mem_mode) begin
            if (xa.le_hi) ext_hi = xa.bus_o;
            if (xa.le_lo) ext_lo = xa.bus_o;
            if (!xa.WEb) ext_mem[{ext_hi, ext_lo}] = xa.bus_o;
            if (!xa.OEb) mem_bus = ext_rd({ext_hi, ext_lo});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from a negedge; returns at 1 time unit past the rsp_valid negedge.
    task automatic op(input int inst, input logic we, input logic [15:0] addr,
                      input logic [7:0] wd, input logic [7:0] bi, output int lat,
                      output logic [7:0] rd, output logic rr, output logic boe);
        logic rv;
        mon_sel = inst;
        if (inst == 0) begin
            xa.req_valid = 1'b1; xa.req_we = we; xa.req_addr = addr; xa.req_wdata = wd;
            bus_a = bi;
        end else begin
            xb.req_valid = 1'b1; xb.req_we = we; xb.req_addr = addr; xb.req_wdata = wd;
            bus_b = bi;
        end
        @(posedge clk);
        #1;
        xa.req_valid = 1'b0;
        xb.req_valid = 1'b0;
        clr_gen++;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            rv = (inst == 0) ? xa.rsp_valid : xb.rsp_valid;
        end while (!rv && lat < 40);
        rd  = (inst == 0) ? xa.rsp_rdata : xb.rsp_rdata;
        rr  = (inst == 0) ? xa.req_ready : xb.req_ready;
        boe = (inst == 0) ? xa.bus_oe : xb.bus_oe;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [7:0]  rd, d;
        logic        rr, boe, w, hit, mhi_valid;
        logic [7:0]  mhi;
        logic [15:0] a;
        int          idx;

        rst = 1'b1;
        xa.req_valid = 1'b0; xa.req_we = 1'b0; xa.req_addr = '0; xa.req_wdata = '0;
        xb.req_valid = 1'b0; xb.req_we = 1'b0; xb.req_addr = '0; xb.req_wdata = '0;
        bus_a = 8'h00; bus_b = 8'h00; mem_bus = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", xa.req_ready, 1);
        chk("rst_rsp_valid", xa.rsp_valid, 0);
        chk("rst_rsp_rdata", xa.rsp_rdata, 0);
        chk("rst_bus_o", xa.bus_o, 0);
        chk("rst_bus_oe", xa.bus_oe, 0);
        chk("rst_le", {xa.le_hi, xa.le_lo}, 0);
        chk("rst_oeb_web", {xa.OEb, xa.WEb}, 2'b11);
        #1;

        // Read 0x0000: hi phase despite matching reset value of last_hi
        op(0, 1'b0, 16'h0000, 8'h00, 8'hE8, lat, rd, rr, boe);
        chk("rd0_lat", lat, 6);
        chk("rd0_lehi", n_lehi, 1);
        chk("rd0_lelo", n_lelo, 1);
        chk("rd0_oe_cycles", n_oe, 1);
        chk("rd0_oe_first", oe_first, 5);
        chk("rd0_we_cycles", n_we, 0);
        chk("rd0_rdata", rd, 8'hE8);
        chk("rd0_ready_at_rsp", rr, 1);
        chk("rd0_oe_at_rsp", boe, 0);

        // Read 0x1234 then 0x1235 back to back; second reuses the high byte
        op(0, 1'b0, 16'h1234, 8'h00, 8'h11, lat, rd, rr, boe);
        chk("rd1_lat", lat, 6);
        chk("rd1_hi_lat", hi_lat, 8'h12);
        chk("rd1_lo_lat", lo_lat, 8'h34);
        chk("rd1_rdata", rd, 8'h11);
        op(0, 1'b0, 16'h1235, 8'h00, 8'h22, lat, rd, rr, boe);
        chk("rd2_lat", lat, 4);
        chk("rd2_lehi", n_lehi, 0);
        chk("rd2_lo_lat", lo_lat, 8'h35);
        chk("rd2_oe_first", oe_first, 3);
        chk("rd2_rdata", rd, 8'h22);

        // Write with high-byte hit, no wait states
        op(0, 1'b1, 16'h1240, 8'hA5, 8'h00, lat, rd, rr, boe);
        chk("wr0_lat", lat, 5);
        chk("wr0_lehi", n_lehi, 0);
        chk("wr0_lo_lat", lo_lat, 8'h40);
        chk("wr0_we_cycles", n_we, 1);
        chk("wr0_wbus", wbus, 8'hA5);
        chk("wr0_wrh_bus", {wrh_oe, wrh_bus}, {1'b1, 8'hA5});
        chk("wr0_oe_cycles", n_oe, 0);
        chk("wr0_conflict", n_conf, 0);

        // Two wait states: write 0x0FA0 <= 0x58, then read with hi hit
        op(1, 1'b1, 16'h0FA0, 8'h58, 8'h00, lat, rd, rr, boe);
        chk("wrb_lat", lat, 9);
        chk("wrb_hi_lat", hi_lat, 8'h0F);
        chk("wrb_lo_lat", lo_lat, 8'hA0);
        chk("wrb_we_cycles", n_we, 3);
        chk("wrb_wbus", wbus, 8'h58);
        chk("wrb_wrh_bus", {wrh_oe, wrh_bus}, {1'b1, 8'h58});
        chk("wrb_oe_cycles", n_oe, 0);
        op(1, 1'b0, 16'h0F01, 8'h00, 8'h3C, lat, rd, rr, boe);
        chk("rdb_lat", lat, 6);
        chk("rdb_lehi", n_lehi, 0);
        chk("rdb_oe_cycles", n_oe, 3);
        chk("rdb_rdata", rd, 8'h3C);

        // Reset during DATA of a write (hi hit, so DATA is cycle 3)
        mon_sel = 0;
        xa.req_valid = 1'b1; xa.req_we = 1'b1; xa.req_addr = 16'h1250; xa.req_wdata = 8'h77;
        @(posedge clk);
        #1 xa.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_web_low", xa.WEb, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_web_high", xa.WEb, 1);
        chk("rstw_no_rsp", xa.rsp_valid, 0);
        chk("rstw_bus_oe", xa.bus_oe, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 clr_gen++;
        repeat (4) @(negedge clk);
        #1;
        chk("rstw_quiet", n_rsp, 0);
        op(0, 1'b0, 16'h1255, 8'h00, 8'h99, lat, rd, rr, boe);
        chk("rstw_rd_lehi", n_lehi, 1);
        chk("rstw_rd_lat", lat, 6);
        chk("rstw_rd_rdata", rd, 8'h99);

`ifdef AS2650_XBUS_READY_EN
        // ready_i low for the first four DATA cycles
        rdy_a = 1'b0; bus_a = 8'h00; mon_sel = 0;
        xa.req_valid = 1'b1; xa.req_we = 1'b0; xa.req_addr = 16'h1256;
        @(posedge clk);
        #1 xa.req_valid = 1'b0;
        clr_gen++;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 7) begin rdy_a = 1'b1; bus_a = 8'h6B; end
        end while (!xa.rsp_valid && lat < 40);
        #1;
        chk("rdy_lat", lat, 8);
        chk("rdy_oe_cycles", n_oe, 5);
        chk("rdy_rdata", xa.rsp_rdata, 8'h6B);
`endif

        // Random back-to-back stream against the pad-side memory
        mem_mode = 1'b1;
        mhi = 8'h12;
        mhi_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idx = int'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            a   = {8'h20 + 8'(idx / 4), 8'(idx % 4)};
            hit = mhi_valid && (mhi == a[15:8]);
            op(0, w, a, d, 8'h00, lat, rd, rr, boe);
            chk("stream_lat", lat, (w ? 5 : 4) + (hit ? 0 : 2));
            chk("stream_conflict", n_conf, 0);
            if (w) ref_mem[a] = d;
            else chk("stream_rdata", rd, ref_rd(a));
            mhi = a[15:8];
            mhi_valid = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            a = {8'h20 + 8'(i / 4), 8'(i % 4)};
            chk("stream_mem", ext_rd(a), ref_rd(a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
